// File: rtl/io_pkg.sv
// ============================================================================
//  Module      : io_pkg
//  Description : Shared defaults and channel state encodings for io_unit.
//                Holds the parameter defaults (data width, channel counts,
//                select width) and the two-state encodings used by the input
//                (EMPTY/FULL) and output (IDLE/PEND) channel FSMs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

    localparam int c_DEF_W     = 8;
    localparam int c_DEF_N_IN  = 2;
    localparam int c_DEF_N_OUT = 4;
    localparam int c_DEF_SEL_W = 2;

    // Input channel: EMPTY means the holding register may accept new data.
    typedef enum logic [0:0] {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

    // Output channel: PEND means out_data is waiting for the consumer.
    typedef enum logic [0:0] {
        OUT_IDLE = 1'b0,
        OUT_PEND = 1'b1
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/io_out_chan.sv
// ============================================================================
//  Module      : io_out_chan
//  Description : One CPU-to-consumer output channel: IDLE/PEND FSM, data
//                register and sticky overflow flag.
//  Ports       : clk, reset (async, active-low)
//                wr_stb   - CPU write addressed to this channel
//                wr_data  - write data
//                ack      - consumer acknowledge
//                data     - output register
//                valid    - channel pending
//                ovf      - sticky: a write arrived while pending, unacked
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_out_chan
    import io_pkg::*;
#(
    parameter int W = c_DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_stb,
    input  logic [W-1:0] wr_data,
    input  logic         ack,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         ovf
);

    out_state_t   r_state;
    out_state_t   w_state_nxt;
    logic         w_load;
    logic         w_ovf_set;
    logic [W-1:0] r_data;
    logic         r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= OUT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            OUT_IDLE: begin
                // ack while idle carries no meaning and is ignored
                if (wr_stb) begin
                    w_load      = 1'b1;
                    w_state_nxt = OUT_PEND;
                end
            end
            OUT_PEND: begin
                if (wr_stb && ack) begin
                    // consumer takes old data as the new write lands
                    w_load = 1'b1;
                end else if (wr_stb) begin
                    // consumer still busy: the write is lost, flag it
                    w_ovf_set = 1'b1;
                end else if (ack) begin
                    w_state_nxt = OUT_IDLE;
                end
            end
            default: begin
                w_state_nxt = OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= wr_data;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign data  = r_data;
    assign valid = (r_state == OUT_PEND);
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/io_unit.sv
// ============================================================================
//  Module      : io_unit
//  Description : CPU-facing I/O block with N_IN input channels (producer ->
//                holding register -> CPU read) and N_OUT output channels
//                (CPU write -> output register -> consumer acknowledge).
//  Ports       : clk, reset (async, active-low)
//                wr_en/wr_sel/wr_data  - CPU write to an output channel
//                rd_en/rd_sel/rd_data  - CPU read (consumes) an input channel;
//                                        rd_data is combinational
//                in_data/in_valid/in_ready    - producer side, per channel
//                out_data/out_valid/out_ack   - consumer side, per channel
//                out_ovf                      - sticky dropped-write flags
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_unit
    import io_pkg::*;
#(
    parameter int W     = c_DEF_W,
    parameter int N_IN  = c_DEF_N_IN,
    parameter int N_OUT = c_DEF_N_OUT,
    parameter int SEL_W = c_DEF_SEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic [W-1:0]       wr_data,
    input  logic               rd_en,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [W-1:0]       rd_data,
    input  logic [N_IN*W-1:0]  in_data,
    input  logic [N_IN-1:0]    in_valid,
    output logic [N_IN-1:0]    in_ready,
    output logic [N_OUT*W-1:0] out_data,
    output logic [N_OUT-1:0]   out_valid,
    input  logic [N_OUT-1:0]   out_ack,
    output logic [N_OUT-1:0]   out_ovf
);

    // Flattened view of all input holding registers for the read mux.
    logic [N_IN*W-1:0] w_hold;
    logic [N_IN-1:0]   w_rd_stb;
    logic [N_OUT-1:0]  w_wr_stb;

    // Select decode: out-of-range selects never match any channel, so such
    // reads and writes fall through with no effect.
    always_comb begin
        w_rd_stb = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_rd_stb[i] = rd_en && (rd_sel == SEL_W'(i));
        end
    end

    always_comb begin
        w_wr_stb = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_wr_stb[j] = wr_en && (wr_sel == SEL_W'(j));
        end
    end

    // ------------------------------------------------------------------
    // Input channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_chan
        in_state_t    r_state;
        in_state_t    w_state_nxt;
        logic         w_capture;
        logic [W-1:0] r_hold;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= IN_EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_capture   = 1'b0;
            case (r_state)
                IN_EMPTY: begin
                    if (in_valid[gi]) begin
                        w_capture   = 1'b1;
                        w_state_nxt = IN_FULL;
                    end
                end
                IN_FULL: begin
                    // in_ready is low here, so in_valid is not looked at
                    if (w_rd_stb[gi]) begin
                        w_state_nxt = IN_EMPTY;
                    end
                end
                default: begin
                    w_state_nxt = IN_EMPTY;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_hold <= '0;
            end else if (w_capture) begin
                r_hold <= in_data[gi*W +: W];
            end
        end

        assign in_ready[gi]         = (r_state == IN_EMPTY);
        assign w_hold[gi*W +: W]    = r_hold;
    end

    // Combinational read port; an EMPTY channel still shows its stale value.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = w_hold[i*W +: W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output channels
    // ------------------------------------------------------------------
    for (genvar gj = 0; gj < N_OUT; gj++) begin : g_out_chan
        io_out_chan #(
            .W (W)
        ) u_out_chan (
            .clk     (clk),
            .reset   (reset),
            .wr_stb  (w_wr_stb[gj]),
            .wr_data (wr_data),
            .ack     (out_ack[gj]),
            .data    (out_data[gj*W +: W]),
            .valid   (out_valid[gj]),
            .ovf     (out_ovf[gj])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_io_unit.sv
// ============================================================================
//  Module      : tb_io_unit
//  Description : Self-checking bench for io_unit: directed scenarios followed
//                by a randomized phase, all compared against a behavioural
//                model of the input and output channels.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_unit;

    localparam int W     = 8;
    localparam int N_IN  = 2;
    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic [SEL_W-1:0]   wr_sel;
    logic [W-1:0]       wr_data;
    logic               rd_en;
    logic [SEL_W-1:0]   rd_sel;
    logic [W-1:0]       rd_data;
    logic [N_IN*W-1:0]  in_data;
    logic [N_IN-1:0]    in_valid;
    logic [N_IN-1:0]    in_ready;
    logic [N_OUT*W-1:0] out_data;
    logic [N_OUT-1:0]   out_valid;
    logic [N_OUT-1:0]   out_ack;
    logic [N_OUT-1:0]   out_ovf;

    // Second instance with only three output channels for select-range checks.
    logic               wr_en3;
    logic [SEL_W-1:0]   wr_sel3;
    logic [W-1:0]       wr_data3;
    logic               rd_en3;
    logic [SEL_W-1:0]   rd_sel3;
    logic [W-1:0]       rd_data3;
    logic [N_IN*W-1:0]  in_data3;
    logic [N_IN-1:0]    in_valid3;
    logic [N_IN-1:0]    in_ready3;
    logic [3*W-1:0]     out_data3;
    logic [2:0]         out_valid3;
    logic [2:0]         out_ack3;
    logic [2:0]         out_ovf3;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [W-1:0] m_hold [N_IN];
    bit           m_full [N_IN];
    logic [W-1:0] m_od   [N_OUT];
    bit           m_pend [N_OUT];
    bit           m_ovf  [N_OUT];

    always #5 clk = ~clk;

    io_unit #(.W(W), .N_IN(N_IN), .N_OUT(N_OUT), .SEL_W(SEL_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .out_ovf   (out_ovf)
    );

    io_unit #(.W(W), .N_IN(N_IN), .N_OUT(3), .SEL_W(SEL_W)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en3),
        .wr_sel    (wr_sel3),
        .wr_data   (wr_data3),
        .rd_en     (rd_en3),
        .rd_sel    (rd_sel3),
        .rd_data   (rd_data3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ack   (out_ack3),
        .out_ovf   (out_ovf3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_IN; i++) begin
            m_hold[i] = '0;
            m_full[i] = 1'b0;
        end
        for (int j = 0; j < N_OUT; j++) begin
            m_od[j]   = '0;
            m_pend[j] = 1'b0;
            m_ovf[j]  = 1'b0;
        end
    endtask

    // One clock edge of the channel rules, from the current inputs.
    task automatic model_edge();
        for (int i = 0; i < N_IN; i++) begin
            if (!m_full[i]) begin
                if (in_valid[i]) begin
                    m_full[i] = 1'b1;
                    m_hold[i] = in_data[i*W +: W];
                end
            end else if (rd_en && int'(rd_sel) == i) begin
                m_full[i] = 1'b0;
            end
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (wr_en && int'(wr_sel) == j) begin
                if (m_pend[j] && !out_ack[j]) begin
                    m_ovf[j] = 1'b1;
                end else begin
                    m_od[j]   = wr_data;
                    m_pend[j] = 1'b1;
                end
            end else if (out_ack[j]) begin
                m_pend[j] = 1'b0;
            end
        end
    endtask

    function automatic logic [W-1:0] exp_rd();
        int idx = int'(rd_sel);
        if (idx < N_IN) return m_hold[idx];
        return '0;
    endfunction

    task automatic check_all(input string tag);
        logic [N_IN-1:0]    e_ready;
        logic [N_OUT-1:0]   e_valid;
        logic [N_OUT-1:0]   e_ovf;
        logic [N_OUT*W-1:0] e_data;
        for (int i = 0; i < N_IN; i++) e_ready[i] = !m_full[i];
        for (int j = 0; j < N_OUT; j++) begin
            e_valid[j]       = m_pend[j];
            e_ovf[j]         = m_ovf[j];
            e_data[j*W +: W] = m_od[j];
        end
        check({tag, ".in_ready"},  64'(in_ready),  64'(e_ready));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
        check({tag, ".out_data"},  64'(out_data),  64'(e_data));
        check({tag, ".out_ovf"},   64'(out_ovf),   64'(e_ovf));
    endtask

    // Called at posedge+1 with inputs already driven.
    task automatic step(input string tag);
        #1;
        check({tag, ".rd_data"}, 64'(rd_data), 64'(exp_rd()));
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        rd_en = 1'b0; rd_sel = '0;
        in_data = '0; in_valid = '0; out_ack = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        wr_en3 = 1'b0; wr_sel3 = '0; wr_data3 = '0;
        rd_en3 = 1'b0; rd_sel3 = '0;
        in_data3 = '0; in_valid3 = '0; out_ack3 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        check_all("reset");
        check("reset.in_ready_lit", 64'(in_ready), 64'h3);

        // Input channel 1 capture, then read with in_valid held high
        in_valid = 2'b10; in_data = {8'hA5, 8'h00};
        step("in_capture");
        in_valid = '0;
        step("in_hold");
        check("in1.not_ready", 64'(in_ready[1]), 64'h0);
        rd_en = 1'b1; rd_sel = 2'd1; in_valid = 2'b10; in_data = {8'h5E, 8'h00};
        #1 check("in1.rd_data_pre", 64'(rd_data), 64'hA5);
        step("in_read");
        check("in1.ready_after", 64'(in_ready[1]), 64'h1);
        idle_inputs();
        // Read of an empty channel: stale data, no state change
        rd_en = 1'b1; rd_sel = 2'd1;
        step("empty_read");
        idle_inputs();

        // Overflow on channel 2
        wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'h3C;
        step("ovf_first");
        idle_inputs();
        repeat (3) step("ovf_wait");
        wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'h77;
        step("ovf_drop");
        check("ovf.data2", 64'(out_data[2*W +: W]), 64'h3C);
        check("ovf.flag2", 64'(out_ovf[2]), 64'h1);
        idle_inputs();

        // Ack and write in the same cycle on channel 0
        wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'h11;
        step("ackwr_first");
        wr_data = 8'h22; out_ack = 4'b0001;
        step("ackwr_both");
        check("ackwr.data0", 64'(out_data[W-1:0]), 64'h22);
        check("ackwr.ovf0", 64'(out_ovf[0]), 64'h0);
        idle_inputs();
        out_ack = 4'b1111;
        step("ack_all");
        out_ack = 4'b0000;
        step("ack_idle");

        // Out-of-range selects on the three-channel instance
        in_valid3 = 2'b11; in_data3 = 16'h5A6B;
        step("range_load");
        in_valid3 = '0;
        wr_en3 = 1'b1; wr_sel3 = 2'd3; wr_data3 = 8'hFF;
        rd_en3 = 1'b1; rd_sel3 = 2'd3;
        #1 check("range.rd_data3", 64'(rd_data3), 64'h0);
        step("range_edge");
        check("range.in_ready3",  64'(in_ready3),  64'h0);
        check("range.out_valid3", 64'(out_valid3), 64'h0);
        check("range.out_data3",  64'(out_data3),  64'h0);
        check("range.out_ovf3",   64'(out_ovf3),   64'h0);
        wr_en3 = 1'b0; rd_en3 = 1'b0;

        // Mid-cycle asynchronous reset with channel 0 FULL and PEND
        in_valid = 2'b01; in_data = 16'h00C3;
        wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'h99;
        step("async_setup");
        idle_inputs();
        check("async.pre_valid0", 64'(out_valid[0]), 64'h1);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check("async.in_ready0", 64'(in_ready[0]), 64'h1);
        check("async.out_valid0", 64'(out_valid[0]), 64'h0);
        check("async.out_data0", 64'(out_data[W-1:0]), 64'h0);
        check_all("async");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = N_IN'($urandom);
            in_data  = (N_IN*W)'($urandom);
            rd_en    = 1'($urandom);
            rd_sel   = SEL_W'($urandom);
            wr_en    = 1'($urandom);
            wr_sel   = SEL_W'($urandom);
            wr_data  = W'($urandom);
            out_ack  = N_OUT'($urandom) & N_OUT'($urandom);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameter W, default 8: data width of every channel.
REQ-002 Parameter N_IN, default 2, range 1..16: number of input channels.
REQ-003 Parameter N_OUT, default 4, range 1..16: number of output channels.
REQ-004 Parameter SEL_W, default 2: channel-select width; SHALL satisfy 2**SEL_W >= max(N_IN, N_OUT).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  CPU write strobe to an output channel.
REQ-008 wr_sel  in  SEL_W  output channel addressed by the write.
REQ-009 wr_data  in  W  write data.
REQ-010 rd_en  in  1  CPU read strobe; consumes the input channel.
REQ-011 rd_sel  in  SEL_W  input channel addressed by the read.
REQ-012 rd_data  out  W  read data, combinational.
REQ-013 in_data  in  N_IN*W  input channel data; channel i is in bits [i*W +: W].
REQ-014 in_valid  in  N_IN  producer valid, one bit per channel.
REQ-015 in_ready  out  N_IN  holding register empty, one bit per channel.
REQ-016 out_data  out  N_OUT*W  output registers; channel j is in bits [j*W +: W].
REQ-017 out_valid  out  N_OUT  output pending, one bit per channel.
REQ-018 out_ack  in  N_OUT  consumer acknowledge, one bit per channel.
REQ-019 out_ovf  out  N_OUT  sticky flag: write dropped.

Function
REQ-020 Each input channel SHALL be a two-state FSM, EMPTY/FULL; in_ready[i] = (state == EMPTY), driven from the register only.
REQ-021 EMPTY with in_valid[i]=1: capture in_data[i] and enter FULL on that edge.
REQ-022 FULL with rd_en=1 and rd_sel==i: enter EMPTY on that edge; in_valid[i] in the same cycle is ignored because in_ready is low.
REQ-023 rd_data SHALL equal holding register [rd_sel] for rd_sel < N_IN, else 0.
REQ-024 A read of an EMPTY channel returns the stale value and changes no state.
REQ-025 Reads with rd_sel >= N_IN have no effect.
REQ-026 Each output channel SHALL be a two-state FSM, IDLE/PEND; out_valid[j] = (state == PEND).
REQ-027 IDLE with wr_en=1 and wr_sel==j: load out_data[j] <= wr_data and enter PEND; out_valid is visible on the following cycle (1-cycle latency).
REQ-028 PEND with out_ack[j]=1 and no write to j: enter IDLE; out_data[j] holds its value.
REQ-029 PEND with out_ack[j]=1 and a write to j in the same cycle: load the new data and stay PEND; out_ovf is not set.
REQ-030 PEND without out_ack and with a write to j: drop the write and set out_ovf[j]; out_data is unchanged.
REQ-031 out_ack in IDLE SHALL be ignored.
REQ-032 Writes with wr_sel >= N_OUT SHALL be ignored.
REQ-033 Reads and writes in the same cycle are independent.

Reset
REQ-034 Assertion of reset (low) SHALL immediately clear all holding and out_data registers to 0, input FSMs to EMPTY (in_ready all 1), output FSMs to IDLE (out_valid 0), and out_ovf to 0.
REQ-035 Reset asserted mid-handshake SHALL abandon the transfer; no data survives.
REQ-036 out_ovf SHALL be cleared only by reset.

Structure
REQ-037 Package io_pkg SHALL hold the parameter defaults and the EMPTY/FULL and IDLE/PEND state encodings.
REQ-038 The per-output-channel FSM, data register and ovf flag SHALL be sub-module io_out_chan, generated N_OUT times; input channels are inline generate logic.

Verification
REQ-039 Reset then idle -> in_ready=2'b11, out_valid=4'b0000, out_data all 0, out_ovf=0.
REQ-040 in_valid[1]=1 with data 8'hA5 for one cycle, then rd_en with rd_sel=1 -> rd_data=8'hA5 before the read edge, in_ready[1]=0 between, and 1 after the read.
REQ-041 Write 8'h3C to channel 2, hold out_ack low for 3 cycles, write 8'h77 to channel 2 -> out_data[2] stays 8'h3C, out_ovf[2]=1, out_valid[2]=1.
REQ-042 Channel 0 PEND with 8'h11, out_ack[0] and a write of 8'h22 in the same cycle -> out_data[0]=8'h22, out_valid[0] stays 1, out_ovf[0]=0.
REQ-043 Write with wr_sel=3 and read with rd_sel=3 for N_OUT=3, N_IN=2 -> no state change, rd_data=0.
REQ-044 Channel 0 input FULL and output PEND, pulse reset low mid-cycle -> immediate in_ready[0]=1, out_valid[0]=0, and out_data[0]=0 with no clock edge.
